// File: rtl/elc3_pkg.sv
// Shared ELC3 control encodings: FSM states, opcodes, mux selects and the
// registered control-word layout used by elc3_control and the datapath.
package elc3_pkg;

    typedef enum logic [4:0] {
        S_HALT, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN, S_JMP,
        S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3, S_LEA,
        S_TRAP1, S_TRAP2, S_TRAP3, S_TRAP4,
        S_MUL1, S_MUL2, S_MUL3
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] PCMUX_INC  = 2'd0;
    localparam logic [1:0] PCMUX_BUS  = 2'd1;
    localparam logic [1:0] PCMUX_ADDR = 2'd2;
    localparam logic       ADDR1_PC   = 1'b0;
    localparam logic       ADDR1_SR1  = 1'b1;
    localparam logic [1:0] ADDR2_ZERO = 2'd0;
    localparam logic [1:0] ADDR2_OFF6 = 2'd1;
    localparam logic [1:0] ADDR2_OFF9 = 2'd2;
    localparam logic [1:0] ADDR2_OFF11 = 2'd3;
    localparam logic [1:0] DR_IR11_9  = 2'd0;
    localparam logic [1:0] DR_R7      = 2'd1;
    localparam logic [1:0] SR1_IR11_9 = 2'd0;
    localparam logic [1:0] SR1_IR8_6  = 2'd1;
    localparam logic       MARMUX_ZEXT8 = 1'b0;
    localparam logic       MARMUX_ADDR  = 1'b1;
    localparam logic [1:0] ALUK_ADD  = 2'd0;
    localparam logic [1:0] ALUK_AND  = 2'd1;
    localparam logic [1:0] ALUK_NOT  = 2'd2;
    localparam logic [1:0] ALUK_PASS = 2'd3;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic       gate_pc, gate_mdr, gate_mul, gate_alu, gate_marmux;
        logic       addr1mux;
        logic [1:0] addr2mux, pcmux, drmux, sr1mux;
        logic       sr2mux, marmux;
        logic [1:0] aluk;
        logic       mio_en, mul_en, mem_oe, mem_we, halted;
    } ctrl_t;

    localparam ctrl_t CTRL_HALT = '{halted: 1'b1, default: '0};

    function automatic logic is_mem_state(input state_t s);
        return s inside {S_FETCH2, S_LDR2, S_STR3, S_TRAP3};
    endfunction

endpackage

// File: rtl/elc3_wait_timer.sv
// Memory-access wait counter: reloads to MEM_WAIT-1 on state entry and counts
// down to zero; also predicts whether the next cycle is the final wait cycle.
module elc3_wait_timer #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done,
    output logic final_next
);
    localparam logic [3:0] RELOAD = 4'(MEM_WAIT - 1);

    logic [3:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= RELOAD;
        else if (count != '0)
            count <= count - 4'd1;
    end

    assign done       = (count == '0);
    // Outputs are registered, so the final-cycle flag is computed one edge early.
    assign final_next = load ? (RELOAD == '0) : (count == 4'd1);

endmodule

// File: rtl/elc3_control.sv
// ELC3 Moore control FSM with registered outputs.
// Define ELC3_MUL_INSTR_EN to decode opcode 1101 as MUL; otherwise it is a NOP.
module elc3_control
    import elc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic [3:0] IR_15_12,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    input  logic       MUL_R,
    output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
    output logic       GatePC, GateMDR, GateMUL, GateALU, GateMARMUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] PCMUX,
    output logic [1:0] DRMUX,
    output logic [1:0] SR1MUX,
    output logic       SR2MUX,
    output logic       MARMUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN, MUL_EN, Mem_OE, Mem_WE,
    output logic       Halted
);
    state_t state, nxt;
    ctrl_t  ctrl, ctrl_n;
    state_t end_st;
    logic   wait_load, wait_done, wait_final_n;

    elc3_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk        (Clk),
        .rst        (Reset),
        .load       (wait_load),
        .done       (wait_done),
        .final_next (wait_final_n)
    );

    assign end_st    = Run ? S_FETCH1 : S_HALT;
    assign wait_load = is_mem_state(nxt) && (nxt != state);

    always_comb begin
        nxt = state;
        case (state)
            S_HALT:   if (Run) nxt = S_FETCH1;
            S_FETCH1: nxt = S_FETCH2;
            S_FETCH2: if (wait_done) nxt = S_FETCH3;
            S_FETCH3: nxt = S_DECODE;
            S_DECODE: begin
                case (IR_15_12)
                    OP_ADD:  nxt = S_ADD;
                    OP_AND:  nxt = S_AND;
                    OP_NOT:  nxt = S_NOT;
                    OP_BR:   nxt = S_BR;
                    OP_JMP:  nxt = S_JMP;
                    OP_JSR:  nxt = S_JSR1;
                    OP_LDR:  nxt = S_LDR1;
                    OP_STR:  nxt = S_STR1;
                    OP_LEA:  nxt = S_LEA;
                    OP_TRAP: nxt = S_TRAP1;
`ifdef ELC3_MUL_INSTR_EN
                    OP_MUL:  nxt = S_MUL1;
`endif
                    default: nxt = end_st;
                endcase
            end
            S_BR:    nxt = BEN ? S_BR_TAKEN : end_st;
            S_JSR1:  nxt = S_JSR2;
            S_LDR1:  nxt = S_LDR2;
            S_LDR2:  if (wait_done) nxt = S_LDR3;
            S_STR1:  nxt = S_STR2;
            S_STR2:  nxt = S_STR3;
            S_STR3:  if (wait_done) nxt = end_st;
            S_TRAP1: nxt = S_TRAP2;
            S_TRAP2: nxt = S_TRAP3;
            S_TRAP3: if (wait_done) nxt = S_TRAP4;
            S_MUL1:  nxt = S_MUL2;
            S_MUL2:  if (MUL_R) nxt = S_MUL3;
            S_ADD, S_AND, S_NOT, S_BR_TAKEN, S_JMP, S_JSR2, S_LDR3,
            S_LEA, S_TRAP4, S_MUL3:
                     nxt = end_st;
            default: nxt = S_HALT;
        endcase
    end

    // Control word for the state being entered; registered below.
    always_comb begin
        ctrl_n = '0;
        case (nxt)
            S_HALT: ctrl_n.halted = 1'b1;
            S_FETCH1: begin
                ctrl_n.gate_pc = 1'b1;
                ctrl_n.ld_mar  = 1'b1;
                ctrl_n.pcmux   = PCMUX_INC;
                ctrl_n.ld_pc   = 1'b1;
            end
            S_FETCH2, S_LDR2, S_TRAP3: begin
                ctrl_n.mem_oe = 1'b1;
                ctrl_n.mio_en = 1'b1;
                ctrl_n.ld_mdr = wait_final_n;
            end
            S_FETCH3: begin
                ctrl_n.gate_mdr = 1'b1;
                ctrl_n.ld_ir    = 1'b1;
            end
            S_DECODE: ctrl_n.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                ctrl_n.sr1mux   = SR1_IR8_6;
                ctrl_n.sr2mux   = IR_5;
                ctrl_n.aluk     = (nxt == S_ADD) ? ALUK_ADD :
                                  (nxt == S_AND) ? ALUK_AND : ALUK_NOT;
                ctrl_n.gate_alu = 1'b1;
                ctrl_n.ld_reg   = 1'b1;
                ctrl_n.ld_cc    = 1'b1;
                ctrl_n.drmux    = DR_IR11_9;
            end
            S_BR_TAKEN: begin
                ctrl_n.addr1mux = ADDR1_PC;
                ctrl_n.addr2mux = ADDR2_OFF9;
                ctrl_n.pcmux    = PCMUX_ADDR;
                ctrl_n.ld_pc    = 1'b1;
            end
            S_JMP: begin
                ctrl_n.sr1mux   = SR1_IR8_6;
                ctrl_n.addr1mux = ADDR1_SR1;
                ctrl_n.addr2mux = ADDR2_ZERO;
                ctrl_n.pcmux    = PCMUX_ADDR;
                ctrl_n.ld_pc    = 1'b1;
            end
            S_JSR1, S_TRAP1: begin
                ctrl_n.gate_pc = 1'b1;
                ctrl_n.drmux   = DR_R7;
                ctrl_n.ld_reg  = 1'b1;
            end
            S_JSR2: begin
                ctrl_n.pcmux = PCMUX_ADDR;
                ctrl_n.ld_pc = 1'b1;
                if (IR_11) begin
                    ctrl_n.addr1mux = ADDR1_PC;
                    ctrl_n.addr2mux = ADDR2_OFF11;
                end else begin
                    ctrl_n.sr1mux   = SR1_IR8_6;
                    ctrl_n.addr1mux = ADDR1_SR1;
                    ctrl_n.addr2mux = ADDR2_ZERO;
                end
            end
            S_LDR1, S_STR1: begin
                ctrl_n.sr1mux      = SR1_IR8_6;
                ctrl_n.addr1mux    = ADDR1_SR1;
                ctrl_n.addr2mux    = ADDR2_OFF6;
                ctrl_n.marmux      = MARMUX_ADDR;
                ctrl_n.gate_marmux = 1'b1;
                ctrl_n.ld_mar      = 1'b1;
            end
            S_LDR3: begin
                ctrl_n.gate_mdr = 1'b1;
                ctrl_n.ld_reg   = 1'b1;
                ctrl_n.ld_cc    = 1'b1;
                ctrl_n.drmux    = DR_IR11_9;
            end
            S_STR2: begin
                ctrl_n.sr1mux   = SR1_IR11_9;
                ctrl_n.aluk     = ALUK_PASS;
                ctrl_n.gate_alu = 1'b1;
                ctrl_n.ld_mdr   = 1'b1;
            end
            S_STR3: ctrl_n.mem_we = 1'b1;
            S_LEA: begin
                ctrl_n.addr1mux    = ADDR1_PC;
                ctrl_n.addr2mux    = ADDR2_OFF9;
                ctrl_n.marmux      = MARMUX_ADDR;
                ctrl_n.gate_marmux = 1'b1;
                ctrl_n.drmux       = DR_IR11_9;
                ctrl_n.ld_reg      = 1'b1;
                ctrl_n.ld_cc       = 1'b1;
            end
            S_TRAP2: begin
                ctrl_n.marmux      = MARMUX_ZEXT8;
                ctrl_n.gate_marmux = 1'b1;
                ctrl_n.ld_mar      = 1'b1;
            end
            S_TRAP4: begin
                ctrl_n.gate_mdr = 1'b1;
                ctrl_n.pcmux    = PCMUX_BUS;
                ctrl_n.ld_pc    = 1'b1;
            end
            S_MUL1: begin
                ctrl_n.mul_en = 1'b1;
                ctrl_n.sr1mux = SR1_IR8_6;
                ctrl_n.sr2mux = IR_5;
            end
            S_MUL3: begin
                ctrl_n.gate_mul = 1'b1;
                ctrl_n.ld_reg   = 1'b1;
                ctrl_n.ld_cc    = 1'b1;
                ctrl_n.drmux    = DR_IR11_9;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_HALT;
            ctrl  <= CTRL_HALT;
        end else begin
            state <= nxt;
            ctrl  <= ctrl_n;
        end
    end

    assign LD_MAR     = ctrl.ld_mar;
    assign LD_MDR     = ctrl.ld_mdr;
    assign LD_IR      = ctrl.ld_ir;
    assign LD_BEN     = ctrl.ld_ben;
    assign LD_REG     = ctrl.ld_reg;
    assign LD_CC      = ctrl.ld_cc;
    assign LD_PC      = ctrl.ld_pc;
    assign GatePC     = ctrl.gate_pc;
    assign GateMDR    = ctrl.gate_mdr;
    assign GateMUL    = ctrl.gate_mul;
    assign GateALU    = ctrl.gate_alu;
    assign GateMARMUX = ctrl.gate_marmux;
    assign ADDR1MUX   = ctrl.addr1mux;
    assign ADDR2MUX   = ctrl.addr2mux;
    assign PCMUX      = ctrl.pcmux;
    assign DRMUX      = ctrl.drmux;
    assign SR1MUX     = ctrl.sr1mux;
    assign SR2MUX     = ctrl.sr2mux;
    assign MARMUX     = ctrl.marmux;
    assign ALUK       = ctrl.aluk;
    assign MIO_EN     = ctrl.mio_en;
    assign MUL_EN     = ctrl.mul_en;
    assign Mem_OE     = ctrl.mem_oe;
    assign Mem_WE     = ctrl.mem_we;
    assign Halted     = ctrl.halted;

endmodule

// File: tb/tb_elc3_control.sv
// Bench for elc3_control: per-instruction cycle scripts from a reference model,
// directed cases plus $urandom instruction streams, reset mid-access.
module tb_elc3_control;
    localparam int MW = 3;

    logic       Clk = 1'b0;
    logic       Reset, Run, IR_5, IR_11, BEN, MUL_R;
    logic [3:0] IR_15_12;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
    logic       GatePC, GateMDR, GateMUL, GateALU, GateMARMUX;
    logic       ADDR1MUX, SR2MUX, MARMUX;
    logic [1:0] ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK;
    logic       MIO_EN, MUL_EN, Mem_OE, Mem_WE, Halted;

    elc3_control #(.MEM_WAIT(MW)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .IR_15_12(IR_15_12), .IR_5(IR_5),
        .IR_11(IR_11), .BEN(BEN), .MUL_R(MUL_R),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_PC(LD_PC),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateMUL(GateMUL), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .MARMUX(MARMUX), .ALUK(ALUK), .MIO_EN(MIO_EN), .MUL_EN(MUL_EN),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic       gate_pc, gate_mdr, gate_mul, gate_alu, gate_marmux;
        logic       addr1mux;
        logic [1:0] addr2mux, pcmux, drmux, sr1mux;
        logic       sr2mux, marmux;
        logic [1:0] aluk;
        logic       mio_en, mul_en, mem_oe, mem_we, halted;
    } cyc_t;

    cyc_t obs, halt_c;
    assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
                  GatePC, GateMDR, GateMUL, GateALU, GateMARMUX,
                  ADDR1MUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, SR2MUX, MARMUX, ALUK,
                  MIO_EN, MUL_EN, Mem_OE, Mem_WE, Halted};

    int   checks = 0;
    int   errors = 0;
    cyc_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: the cycle-by-cycle output script of one whole instruction.
    task automatic build(input logic [3:0] op, input logic i5, input logic i11, input logic ben);
        cyc_t c;
        c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; q.push_back(c);
        for (int i = 0; i < MW; i++) begin
            c = '0; c.mem_oe = 1; c.mio_en = 1; c.ld_mdr = (i == MW - 1); q.push_back(c);
        end
        c = '0; c.gate_mdr = 1; c.ld_ir = 1; q.push_back(c);
        c = '0; c.ld_ben = 1; q.push_back(c);
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                c = '0; c.sr1mux = 1; c.sr2mux = i5;
                c.aluk = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
                c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; q.push_back(c);
            end
            4'b0000: begin
                c = '0; q.push_back(c);
                if (ben) begin
                    c.ld_pc = 1; c.pcmux = 2; c.addr2mux = 2; q.push_back(c);
                end
            end
            4'b1100: begin
                c = '0; c.ld_pc = 1; c.pcmux = 2; c.addr1mux = 1; c.sr1mux = 1; q.push_back(c);
            end
            4'b0100: begin
                c = '0; c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; q.push_back(c);
                c = '0; c.ld_pc = 1; c.pcmux = 2;
                if (i11) c.addr2mux = 3;
                else begin c.addr1mux = 1; c.sr1mux = 1; end
                q.push_back(c);
            end
            4'b0110, 4'b0111: begin
                c = '0; c.gate_marmux = 1; c.marmux = 1; c.addr1mux = 1; c.addr2mux = 1;
                c.sr1mux = 1; c.ld_mar = 1; q.push_back(c);
                if (op == 4'b0110) begin
                    for (int i = 0; i < MW; i++) begin
                        c = '0; c.mem_oe = 1; c.mio_en = 1; c.ld_mdr = (i == MW - 1); q.push_back(c);
                    end
                    c = '0; c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; q.push_back(c);
                end else begin
                    c = '0; c.aluk = 3; c.gate_alu = 1; c.ld_mdr = 1; q.push_back(c);
                    for (int i = 0; i < MW; i++) begin
                        c = '0; c.mem_we = 1; q.push_back(c);
                    end
                end
            end
            4'b1110: begin
                c = '0; c.addr2mux = 2; c.marmux = 1; c.gate_marmux = 1;
                c.ld_reg = 1; c.ld_cc = 1; q.push_back(c);
            end
            4'b1111: begin
                c = '0; c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; q.push_back(c);
                c = '0; c.gate_marmux = 1; c.ld_mar = 1; q.push_back(c);
                for (int i = 0; i < MW; i++) begin
                    c = '0; c.mem_oe = 1; c.mio_en = 1; c.ld_mdr = (i == MW - 1); q.push_back(c);
                end
                c = '0; c.gate_mdr = 1; c.pcmux = 1; c.ld_pc = 1; q.push_back(c);
            end
`ifdef ELC3_MUL_INSTR_EN
            4'b1101: begin
                c = '0; c.mul_en = 1; c.sr1mux = 1; c.sr2mux = i5; q.push_back(c);
                c = '0; q.push_back(c);
                c = '0; c.gate_mul = 1; c.ld_reg = 1; c.ld_cc = 1; q.push_back(c);
            end
`endif
            default: ;
        endcase
    endtask

    function automatic cyc_t fetch1_c();
        cyc_t c;
        c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1;
        return c;
    endfunction

    // Entered with the DUT showing FETCH1; leaves it showing the next FETCH1.
    task automatic run_instr(input logic [15:0] ir, input logic ben, input logic run_after);
        cyc_t e;
        int   idx, we_cnt;
        IR_15_12 = ir[15:12]; IR_5 = ir[5]; IR_11 = ir[11]; BEN = ben; Run = run_after;
        build(ir[15:12], ir[5], ir[11], ben);
        idx = 0; we_cnt = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("ir%h_c%0d", ir, idx), {2'b00, obs}, {2'b00, e});
            if (Mem_WE && Mem_OE) chk("we_with_oe", 32'(Mem_OE), 32'd0);
            we_cnt += int'(Mem_WE);
            idx++;
            @(posedge Clk); #1;
        end
        chk($sformatf("ir%h_we_len", ir), 32'(we_cnt), (ir[15:12] == 4'b0111) ? 32'(MW) : 32'd0);
        if (!run_after) begin
            chk($sformatf("ir%h_halt", ir), {2'b00, obs}, {2'b00, halt_c});
            Run = 1'b1;
            @(posedge Clk); #1;
        end
        chk($sformatf("ir%h_next", ir), {2'b00, obs}, {2'b00, fetch1_c()});
    endtask

    logic [15:0] dir_ir  [19] = '{16'h1261, 16'h0402, 16'h0402, 16'h7283, 16'h6283,
                                  16'hF025, 16'h4800, 16'h4080, 16'hC1C0, 16'h927F,
                                  16'h5260, 16'h5042, 16'hE205, 16'hD261, 16'h8000,
                                  16'hA000, 16'hB000, 16'h3000, 16'h1060};
    logic        dir_ben [19] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    logic        dir_run [19] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1};

    initial begin
        halt_c = '0; halt_c.halted = 1'b1;
        Reset = 1'b1; Run = 1'b0; IR_15_12 = '0; IR_5 = 0; IR_11 = 0; BEN = 0; MUL_R = 1'b1;
        repeat (2) @(posedge Clk);
        #1 chk("reset_state", {2'b00, obs}, {2'b00, halt_c});
        @(negedge Clk); Reset = 1'b0; Run = 1'b1;
        @(posedge Clk); #1;
        chk("reset_to_fetch1", {2'b00, obs}, {2'b00, fetch1_c()});

        for (int i = 0; i < 19; i++) run_instr(dir_ir[i], dir_ben[i], dir_run[i]);
        for (int i = 0; i < 40; i++)
            run_instr(16'($urandom), 1'($urandom), $urandom_range(0, 4) != 0);

        // Asynchronous reset in the middle of a memory wait.
        @(posedge Clk); #1;
        #2 Reset = 1'b1;
        #1 chk("rst_mid_mem", {2'b00, obs}, {2'b00, halt_c});
        @(negedge Clk); Reset = 1'b0; Run = 1'b0;
        @(posedge Clk); #1 chk("halt_hold", {2'b00, obs}, {2'b00, halt_c});
        Run = 1'b1;
        @(posedge Clk); #1 chk("restart", {2'b00, obs}, {2'b00, fetch1_c()});
        run_instr(16'h7283, 1'b0, 1'b1);

`ifdef ELC3_MUL_INSTR_EN
        // Multiplier stall, then reset while waiting for MUL_R.
        MUL_R = 1'b0;
        IR_15_12 = 4'b1101; IR_5 = 1'b1; IR_11 = 1'b0;
        build(4'b1101, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < MW + 4; i++) begin
            chk($sformatf("mul_pre_c%0d", i), {2'b00, obs}, {2'b00, q.pop_front()});
            @(posedge Clk); #1;
        end
        q.delete();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("mul2_stall_%0d", i), {2'b00, obs}, 32'd0);
            @(posedge Clk); #1;
        end
        #2 Reset = 1'b1;
        #1 chk("rst_in_mul2", {2'b00, obs}, {2'b00, halt_c});
        @(negedge Clk); Reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/elc3_control.md
ELC3_CONTROL -- requirements
Module: elc3_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, number of wait cycles held in each memory-access state (legal range 1..15).
REQ-002 SHALL have port Clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Run  input  1  level start request; leaves HALT when high.
REQ-005 SHALL have ports IR_15_12 (4), IR_5 (1), IR_11 (1), BEN (1), MUL_R (1)  inputs  datapath status.
REQ-006 SHALL have outputs LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC  1 each  register loads.
REQ-007 SHALL have outputs GatePC, GateMDR, GateMUL, GateALU, GateMARMUX  1 each  bus gates, at most one high per cycle.
REQ-008 SHALL have outputs ADDR1MUX (1), ADDR2MUX (2), PCMUX (2), DRMUX (2), SR1MUX (2), SR2MUX (1), MARMUX (1), ALUK (2)  mux selects.
REQ-009 SHALL have outputs MIO_EN, MUL_EN, Mem_OE, Mem_WE  1 each  memory/multiplier controls; output Halted  1  high in HALT.

Function
REQ-010 SHALL be a Moore FSM; every output 0 unless the current state asserts it.
REQ-011 SHALL sequence FETCH1 (GatePC, LD_MAR, PCMUX=0, LD_PC) -> FETCH2 (Mem_OE, MIO_EN, LD_MDR on final wait cycle) -> FETCH3 (GateMDR, LD_IR) -> DECODE (LD_BEN).
REQ-012 SHALL dispatch from DECODE on IR_15_12: ADD 0001, AND 0101, NOT 1001, BR 0000, JMP 1100, JSR 0100, LDR 0110, STR 0111, LEA 1110, TRAP 1111, MUL 1101; any other opcode returns to FETCH1 as a NOP.
REQ-013 SHALL execute ADD/AND/NOT in one cycle: SR1MUX=1, SR2MUX=IR_5, ALUK=0/1/2, GateALU, LD_REG, LD_CC, DRMUX=0.
REQ-014 SHALL for BR load PC (ADDR1MUX=0, ADDR2MUX=2, PCMUX=2) only when BEN=1; otherwise return to FETCH1 with PC untouched.
REQ-015 SHALL for JSR first write R7 (GatePC, DRMUX=1, LD_REG), then load PC with PC+off11 if IR_11=1, else SR1 (PCMUX=2, ADDR1MUX=1, ADDR2MUX=0).
REQ-016 SHALL for LDR/STR compute MAR from SR1+off6, then perform one memory access of exactly MEM_WAIT cycles; STR asserts Mem_WE only during its wait state, with MDR loaded from SR1 (SR1MUX=0, ALUK=3, GateALU) beforehand.
REQ-017 SHALL for TRAP write R7<-PC, MAR<-ZEXT(IR[7:0]) (MARMUX=0), read memory, then PC<-MDR (GateMDR, PCMUX=1).
REQ-018 SHALL hold a 4-bit wait counter reloaded to MEM_WAIT-1 on memory-state entry; exit when it reaches 0.
REQ-019 SHALL after each instruction enter FETCH1 if Run=1, else HALT.

Reset
REQ-020 SHALL on Reset immediately enter HALT and clear wait counter, deasserting every output except Halted=1, including mid-memory or mid-multiply.

Configuration
REQ-021 SHALL with ELC3_MUL_INSTR_EN defined execute MUL: MUL1 asserts MUL_EN one cycle (SR2MUX=IR_5), MUL2 waits until MUL_R=1, MUL3 asserts GateMUL, LD_REG, LD_CC; MUL_EN never asserted without it and 1101 decodes as NOP.

Structure
REQ-022 SHALL place the state enum, opcode constants, and mux-select/ALUK encodings in package elc3_pkg, shared with the datapath.
REQ-023 SHALL keep the wait counter as sub-module elc3_wait_timer; all else in one module.

Verification
REQ-024 SHALL cover reset release with Run=1 -> FETCH1 next cycle, GatePC=1, LD_MAR=1, LD_PC=1.
REQ-025 SHALL cover IR=0x1261 (ADD) -> DECODE then one cycle GateALU=1, LD_REG=1, LD_CC=1, SR2MUX=1, ALUK=0.
REQ-026 SHALL cover BR 0x0402 with BEN=0 -> no LD_PC after DECODE; BEN=1 -> LD_PC=1, PCMUX=2.
REQ-027 SHALL cover STR with MEM_WAIT=3 -> Mem_WE high exactly 3 consecutive cycles, never with Mem_OE.
REQ-028 SHALL cover MUL with MUL_R held low 10 cycles -> FSM stays in MUL2; Reset pulse there -> HALT, MUL_EN=0, Halted=1.
